// File: rtl/ctrl_pkg.sv
// Shared definitions for the ID-stage control pipe: opcodes, ALU op codes,
// immediate formats, writeback encodings, the control bundle and the MD FSM state.
package ctrl_pkg;

    // Internal ALU code width; the top zero-extends to its ALUOP_W parameter.
    localparam int ALU_CODE_W = 5;

    // RV32 base opcodes (instruction bits [6:0]).
    localparam logic [6:0] OP_NOP    = 7'b0000000;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // ALU operation codes. M-extension ops occupy 8..15 so that they can be
    // built directly from funct3 as {2'b01, funct3}.
    typedef enum logic [ALU_CODE_W-1:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SLL    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_MUL    = 5'd8,
        ALU_MULH   = 5'd9,
        ALU_MULHSU = 5'd10,
        ALU_MULHU  = 5'd11,
        ALU_DIV    = 5'd12,
        ALU_DIVU   = 5'd13,
        ALU_REM    = 5'd14,
        ALU_REMU   = 5'd15,
        ALU_SLT    = 5'd16,
        ALU_SLTU   = 5'd17
    } alu_op_e;

    // Immediate format selector for the immediate generator.
    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

    // Writeback mux (MUX3) encodings.
    localparam logic [1:0] WB_IMM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // Datapath control bundle held in the ID/EX register.
    typedef struct packed {
        logic       mux1;
        logic       mux2;
        logic [1:0] mux3;
        logic       mux4;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic       jump;
        logic       we;
        alu_op_e    aluop;
        imm_sel_e   imm_sel;
    } ctrl_t;

    // Full decoder result: bundle plus classification flags.
    typedef struct packed {
        ctrl_t ctrl;
        logic  illegal;
        logic  is_mul;
        logic  is_div;
    } dec_t;

    // Multi-cycle sequencer states.
    typedef enum logic {
        IDLE    = 1'b0,
        MD_WAIT = 1'b1
    } md_state_e;

    // Shared funct3 -> ALU op mapping for register and immediate ALU forms.
    // 'alt' is instruction bit 30; it selects SRA always, and SUB only when
    // allow_sub is set (ADDI has no subtract form).
    function automatic alu_op_e alu_fn(input logic [2:0] funct3,
                                       input logic       alt,
                                       input logic       allow_sub);
        alu_op_e op;
        op = ALU_ADD;
        case (funct3)
            3'b000: if (alt && allow_sub) op = ALU_SUB;
                    else                  op = ALU_ADD;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_SLTU;
            3'b100: op = ALU_XOR;
            3'b101: if (alt) op = ALU_SRA;
                    else     op = ALU_SRL;
            3'b110: op = ALU_OR;
            3'b111: op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/md_seq.sv
// Multi-cycle M-extension sequencer: tracks how long a MUL/DIV-class op
// keeps EX occupied and raises busy for (latency - 1) cycles after issue.
module md_seq
    import ctrl_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic start_mul,
    input  logic start_div,
    output logic busy
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    // Remaining busy cycles after the issue cycle.
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    // FSM with counter and registered busy flag; a zero load count never leaves IDLE.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples
        // pre-edge values; blocking here would create order-dependent races.
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_mul && (MUL_CNT != '0)) begin
                        state_q <= MD_WAIT;
                        cnt_q   <= MUL_CNT;
                        busy_q  <= 1'b1;
                    end else if (start_div && (DIV_CNT != '0)) begin
                        state_q <= MD_WAIT;
                        cnt_q   <= DIV_CNT;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                MD_WAIT: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/id_control_pipe.sv
// Registered RV32IM decode stage: decodes one instruction per cycle into the
// datapath control bundle, holds it in the ID/EX register, and handles
// valid/ready, stall, flush and multi-cycle M-op back-pressure.
module id_control_pipe
    import ctrl_pkg::*;
#(
    parameter int ALUOP_W  = 5,
    parameter int ENABLE_M = 1,
    parameter int MUL_LAT  = 2,
    parameter int DIV_LAT  = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [31:0]        INSTRUCTION,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic               STALL_IN,
    input  logic               FLUSH,
    output logic               OUT_VALID,
    output logic               MUX1_SELECT,
    output logic               MUX2_SELECT,
    output logic [1:0]         MUX3_SELECT,
    output logic               MUX4_SELECT,
    output logic               MEMREAD,
    output logic               MEMWRITE,
    output logic               BRANCH,
    output logic               JUMP,
    output logic               WRITEENABLE,
    output logic [ALUOP_W-1:0] ALUOP,
    output logic [2:0]         IMM_SEL,
    output logic               MD_BUSY,
    output logic               ILLEGAL
);

    // Pure decode of the fields that matter; unused fields stay zero.
    function automatic dec_t decode_instr(input logic [6:0] opcode,
                                          input logic [2:0] funct3,
                                          input logic       f7_30,
                                          input logic       f7_25,
                                          input logic       en_m);
        dec_t d;
        // NOTE: clear the whole result before the case so no path leaves a
        // field unassigned -- that is what keeps the comb logic latch- and X-free.
        d = '0;
        case (opcode)
            OP_NOP: begin
            end
            OP_R: begin
                if (f7_25 && !en_m) begin
                    d.illegal = 1'b1;
                end else begin
                    d.ctrl.mux2 = 1'b1;
                    d.ctrl.mux3 = WB_ALU;
                    d.ctrl.we   = 1'b1;
                    if (f7_25) begin
                        d.ctrl.aluop = alu_op_e'({2'b01, funct3});
                        d.is_mul     = !funct3[2];
                        d.is_div     = funct3[2];
                    end else begin
                        d.ctrl.aluop = alu_fn(funct3, f7_30, 1'b1);
                    end
                end
            end
            OP_IMM: begin
                d.ctrl.mux3    = WB_ALU;
                d.ctrl.we      = 1'b1;
                d.ctrl.aluop   = alu_fn(funct3, f7_30, 1'b0);
                d.ctrl.imm_sel = IMM_I;
            end
            OP_LOAD: begin
                d.ctrl.mux4    = 1'b1;
                d.ctrl.mux3    = WB_ALU;
                d.ctrl.we      = 1'b1;
                d.ctrl.memread = 1'b1;
                d.ctrl.aluop   = ALU_ADD;
                d.ctrl.imm_sel = IMM_I;
            end
            OP_STORE: begin
                d.ctrl.mux4     = 1'b1;
                d.ctrl.memwrite = 1'b1;
                d.ctrl.aluop    = ALU_ADD;
                d.ctrl.imm_sel  = IMM_S;
            end
            OP_BRANCH: begin
                d.ctrl.mux2    = 1'b1;
                d.ctrl.branch  = 1'b1;
                d.ctrl.aluop   = ALU_SUB;
                d.ctrl.imm_sel = IMM_B;
            end
            OP_JALR: begin
                d.ctrl.mux3    = WB_PC4;
                d.ctrl.we      = 1'b1;
                d.ctrl.jump    = 1'b1;
                d.ctrl.aluop   = ALU_ADD;
                d.ctrl.imm_sel = IMM_I;
            end
            OP_JAL: begin
                d.ctrl.mux1    = 1'b1;
                d.ctrl.mux3    = WB_PC4;
                d.ctrl.we      = 1'b1;
                d.ctrl.jump    = 1'b1;
                d.ctrl.aluop   = ALU_ADD;
                d.ctrl.imm_sel = IMM_J;
            end
            OP_AUIPC: begin
                d.ctrl.mux1    = 1'b1;
                d.ctrl.mux3    = WB_ALU;
                d.ctrl.we      = 1'b1;
                d.ctrl.aluop   = ALU_ADD;
                d.ctrl.imm_sel = IMM_U;
            end
            OP_LUI: begin
                d.ctrl.mux3    = WB_IMM;
                d.ctrl.we      = 1'b1;
                d.ctrl.aluop   = ALU_ADD;
                d.ctrl.imm_sel = IMM_U;
            end
            default: begin
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

    dec_t  dec;
    ctrl_t ctrl_q, ctrl_d;
    logic  valid_q, valid_d;
    logic  illegal_q, illegal_d;
    logic  md_busy;
    logic  accept;
    logic  take;
    logic  start_mul;
    logic  start_div;
    logic  unused_instr;

    // Bits the control decode never looks at (register indices, immediates).
    assign unused_instr = ^{INSTRUCTION[31], INSTRUCTION[29:26],
                            INSTRUCTION[24:15], INSTRUCTION[11:7]};

    // Combinational decode of the current IF/ID instruction.
    always_comb begin
        dec = decode_instr(INSTRUCTION[6:0], INSTRUCTION[14:12],
                           INSTRUCTION[30], INSTRUCTION[25], ENABLE_M != 0);
    end

    assign IN_READY  = !md_busy && !STALL_IN;
    assign accept    = IN_VALID && IN_READY;
    // A flushed instruction is dropped entirely: it neither issues nor starts the sequencer.
    assign take      = accept && !FLUSH;
    assign start_mul = take && dec.is_mul;
    assign start_div = take && dec.is_div;

    md_seq #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md_seq (
        .clk       (CLK),
        .reset     (RESET),
        .start_mul (start_mul),
        .start_div (start_div),
        .busy      (md_busy)
    );

    // Next ID/EX contents: flush beats stall beats accept; otherwise a bubble.
    always_comb begin
        ctrl_d    = ctrl_q;
        valid_d   = valid_q;
        illegal_d = 1'b0;
        if (FLUSH) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
        end else if (!STALL_IN) begin
            if (accept) begin
                ctrl_d    = dec.ctrl;
                valid_d   = 1'b1;
                illegal_d = dec.illegal;
            end else begin
                ctrl_d  = '0;
                valid_d = 1'b0;
            end
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ctrl_q    <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
        end
    end

    assign OUT_VALID   = valid_q;
    assign MUX1_SELECT = ctrl_q.mux1;
    assign MUX2_SELECT = ctrl_q.mux2;
    assign MUX3_SELECT = ctrl_q.mux3;
    assign MUX4_SELECT = ctrl_q.mux4;
    assign MEMREAD     = ctrl_q.memread;
    assign MEMWRITE    = ctrl_q.memwrite;
    assign BRANCH      = ctrl_q.branch;
    assign JUMP        = ctrl_q.jump;
    assign WRITEENABLE = ctrl_q.we;
    assign ALUOP       = ALUOP_W'(ctrl_q.aluop);
    assign IMM_SEL     = ctrl_q.imm_sel;
    assign MD_BUSY     = md_busy;
    assign ILLEGAL     = illegal_q;

endmodule

// File: tb/tb_id_control_pipe.sv
// Directed testbench for id_control_pipe: one default instance (M enabled,
// MUL_LAT=2, DIV_LAT=8) and one with ENABLE_M=0 sharing the same inputs.
module tb_id_control_pipe;

    logic        clk;
    logic        reset;
    logic [31:0] instruction;
    logic        in_valid;
    logic        stall_in;
    logic        flush;

    logic        in_ready, out_valid, mux1, mux2, mux4, memread, memwrite;
    logic        branch, jump, we, md_busy, illegal;
    logic [1:0]  mux3;
    logic [4:0]  aluop;
    logic [2:0]  imm_sel;

    logic        in_ready_m0, out_valid_m0, mux1_m0, mux2_m0, mux4_m0, memread_m0, memwrite_m0;
    logic        branch_m0, jump_m0, we_m0, md_busy_m0, illegal_m0;
    logic [1:0]  mux3_m0;
    logic [4:0]  aluop_m0;
    logic [2:0]  imm_sel_m0;

    int checks = 0;
    int errors = 0;
    int n;

    logic [19:0] obs_bnd;
    logic [19:0] e_zero, e_nop, e_add, e_sub, e_lui, e_beq, e_mul, e_div, e_jal;
    logic [19:0] e_jalr, e_sw, e_lw, e_srai, e_sltiu, e_ill;

    id_control_pipe #(.ALUOP_W(5), .ENABLE_M(1), .MUL_LAT(2), .DIV_LAT(8)) u_dut (
        .CLK(clk), .RESET(reset), .INSTRUCTION(instruction), .IN_VALID(in_valid),
        .IN_READY(in_ready), .STALL_IN(stall_in), .FLUSH(flush), .OUT_VALID(out_valid),
        .MUX1_SELECT(mux1), .MUX2_SELECT(mux2), .MUX3_SELECT(mux3), .MUX4_SELECT(mux4),
        .MEMREAD(memread), .MEMWRITE(memwrite), .BRANCH(branch), .JUMP(jump),
        .WRITEENABLE(we), .ALUOP(aluop), .IMM_SEL(imm_sel), .MD_BUSY(md_busy),
        .ILLEGAL(illegal)
    );

    id_control_pipe #(.ALUOP_W(5), .ENABLE_M(0), .MUL_LAT(2), .DIV_LAT(8)) u_dut_m0 (
        .CLK(clk), .RESET(reset), .INSTRUCTION(instruction), .IN_VALID(in_valid),
        .IN_READY(in_ready_m0), .STALL_IN(stall_in), .FLUSH(flush), .OUT_VALID(out_valid_m0),
        .MUX1_SELECT(mux1_m0), .MUX2_SELECT(mux2_m0), .MUX3_SELECT(mux3_m0),
        .MUX4_SELECT(mux4_m0), .MEMREAD(memread_m0), .MEMWRITE(memwrite_m0),
        .BRANCH(branch_m0), .JUMP(jump_m0), .WRITEENABLE(we_m0), .ALUOP(aluop_m0),
        .IMM_SEL(imm_sel_m0), .MD_BUSY(md_busy_m0), .ILLEGAL(illegal_m0)
    );

    assign obs_bnd = {out_valid, mux1, mux2, mux3, mux4, memread, memwrite,
                      branch, jump, we, aluop, imm_sel, illegal};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Expected bundle, packed in the same order as obs_bnd.
    function automatic logic [19:0] bnd(input logic v, input logic m1, input logic m2,
                                        input logic [1:0] m3, input logic m4,
                                        input logic mr, input logic mw, input logic br,
                                        input logic jp, input logic wen,
                                        input logic [4:0] op, input logic [2:0] imm,
                                        input logic ill);
        return {v, m1, m2, m3, m4, mr, mw, br, jp, wen, op, imm, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_bnd(input string tag, input logic [19:0] expected);
        check(tag, {12'd0, obs_bnd}, {12'd0, expected});
    endtask

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        check(tag, {31'd0, observed}, {31'd0, expected});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr);
        in_valid    = v;
        instruction = instr;
    endtask

    // Counts MD_BUSY cycles, including the one already observed, bounded at 20.
    task automatic count_busy(output int cnt);
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (md_busy) cnt++;
            else break;
        end
    endtask

    initial begin
        e_zero  = bnd(0,0,0,2'b00,0,0,0,0,0,0,5'd0, 3'd0,0);
        e_nop   = bnd(1,0,0,2'b00,0,0,0,0,0,0,5'd0, 3'd0,0);
        e_add   = bnd(1,0,1,2'b01,0,0,0,0,0,1,5'd0, 3'd0,0);
        e_sub   = bnd(1,0,1,2'b01,0,0,0,0,0,1,5'd1, 3'd0,0);
        e_lui   = bnd(1,0,0,2'b00,0,0,0,0,0,1,5'd0, 3'd3,0);
        e_beq   = bnd(1,0,1,2'b00,0,0,0,1,0,0,5'd1, 3'd2,0);
        e_mul   = bnd(1,0,1,2'b01,0,0,0,0,0,1,5'd8, 3'd0,0);
        e_div   = bnd(1,0,1,2'b01,0,0,0,0,0,1,5'd12,3'd0,0);
        e_jal   = bnd(1,1,0,2'b10,0,0,0,0,1,1,5'd0, 3'd4,0);
        e_jalr  = bnd(1,0,0,2'b10,0,0,0,0,1,1,5'd0, 3'd0,0);
        e_sw    = bnd(1,0,0,2'b00,1,0,1,0,0,0,5'd0, 3'd1,0);
        e_lw    = bnd(1,0,0,2'b01,1,1,0,0,0,1,5'd0, 3'd0,0);
        e_srai  = bnd(1,0,0,2'b01,0,0,0,0,0,1,5'd7, 3'd0,0);
        e_sltiu = bnd(1,0,0,2'b01,0,0,0,0,0,1,5'd17,3'd0,0);
        e_ill   = bnd(1,0,0,2'b00,0,0,0,0,0,0,5'd0, 3'd0,1);

        reset = 1'b1; stall_in = 1'b0; flush = 1'b0;
        drive(1'b0, 32'h0);
        tick(); tick();
        check_bnd("reset_bundle", e_zero);
        check_bit("reset_md_busy", md_busy, 1'b0);
        check_bit("reset_in_ready", in_ready, 1'b1);
        reset = 1'b0;

        // ADD, SUB
        drive(1'b1, 32'h003100B3); tick(); check_bnd("add", e_add);
        drive(1'b1, 32'h403100B3); tick(); check_bnd("sub", e_sub);

        // LUI then BEQ back-to-back
        drive(1'b1, 32'h123450B7); tick(); check_bnd("lui", e_lui);
        drive(1'b1, 32'h00208063); tick(); check_bnd("beq", e_beq);

        // MUL: one busy cycle, a waiting ADD is accepted only after it
        drive(1'b1, 32'h023100B3); tick();
        check_bnd("mul", e_mul);
        check_bit("mul_busy", md_busy, 1'b1);
        drive(1'b1, 32'h003100B3); #1;
        check_bit("mul_in_ready", in_ready, 1'b0);
        tick();
        check_bnd("mul_wait_bubble", e_zero);
        check_bit("mul_busy_done", md_busy, 1'b0);
        check_bit("mul_ready_again", in_ready, 1'b1);
        tick();
        check_bnd("add_after_mul", e_add);

        // DIV: seven busy cycles
        drive(1'b1, 32'h023140B3); tick();
        check_bnd("div", e_div);
        check_bit("div_busy", md_busy, 1'b1);
        drive(1'b0, 32'h0);
        count_busy(n);
        check("div_busy_cycles", n, 7);
        check_bnd("div_after_bundle", e_zero);

        // Stall held three cycles after ADD
        drive(1'b1, 32'h003100B3); tick(); check_bnd("stall_add", e_add);
        stall_in = 1'b1;
        drive(1'b1, 32'h123450B7); #1;
        for (int i = 0; i < 3; i++) begin
            check_bit("stall_in_ready", in_ready, 1'b0);
            tick();
            check_bnd("stall_hold", e_add);
        end
        stall_in = 1'b0; tick();
        check_bnd("stall_release_lui", e_lui);

        // JAL normally, then with FLUSH
        drive(1'b1, 32'h008000EF); tick(); check_bnd("jal", e_jal);
        flush = 1'b1; tick(); check_bnd("flush_jal", e_zero);

        // FLUSH drops a MUL: no sequencer start
        drive(1'b1, 32'h023100B3); tick();
        check_bnd("flush_mul", e_zero);
        check_bit("flush_mul_busy", md_busy, 1'b0);
        flush = 1'b0;

        // FLUSH during DIV wait does not abort it
        drive(1'b1, 32'h023140B3); tick();
        check_bnd("div2", e_div);
        flush = 1'b1; drive(1'b1, 32'h003100B3);
        count_busy(n);
        check("flush_div_busy_cycles", n, 7);
        flush = 1'b0;

        // Reset during MD_WAIT
        drive(1'b1, 32'h023140B3); tick();
        drive(1'b0, 32'h0); tick();
        check_bit("div3_busy", md_busy, 1'b1);
        reset = 1'b1; tick();
        check_bit("reset_in_wait_busy", md_busy, 1'b0);
        check_bnd("reset_in_wait_bundle", e_zero);
        reset = 1'b0; tick();
        check_bit("after_reset_idle", md_busy, 1'b0);

        // Other formats
        drive(1'b1, 32'h000080E7); tick(); check_bnd("jalr", e_jalr);
        drive(1'b1, 32'h0020A023); tick(); check_bnd("sw", e_sw);
        drive(1'b1, 32'h0000A083); tick(); check_bnd("lw", e_lw);
        drive(1'b1, 32'h4010D093); tick(); check_bnd("srai", e_srai);
        drive(1'b1, 32'h0010B093); tick(); check_bnd("sltiu", e_sltiu);
        drive(1'b1, 32'h00000000); tick(); check_bnd("nop", e_nop);

        // Illegal opcode: one-cycle pulse, then bubble
        drive(1'b1, 32'h0000007F); tick();
        check_bnd("illegal", e_ill);
        check_bit("illegal_no_busy", md_busy, 1'b0);
        drive(1'b0, 32'h0); tick();
        check_bnd("illegal_pulse_end", e_zero);

        // Illegal opcode under FLUSH: no ILLEGAL
        flush = 1'b1; drive(1'b1, 32'h0000007F); tick();
        check_bnd("flush_illegal", e_zero);
        flush = 1'b0; drive(1'b0, 32'h0); tick();

        // ENABLE_M=0 instance: MUL is illegal and never busy
        drive(1'b1, 32'h023100B3); tick();
        check_bit("m0_illegal", illegal_m0, 1'b1);
        check_bit("m0_valid", out_valid_m0, 1'b1);
        check("m0_aluop", {27'd0, aluop_m0}, 32'd0);
        check_bit("m0_we", we_m0, 1'b0);
        check_bit("m0_busy", md_busy_m0, 1'b0);
        check_bit("m1_busy", md_busy, 1'b1);
        drive(1'b0, 32'h0); tick();
        check_bit("m0_illegal_end", illegal_m0, 1'b0);
        check_bit("m0_busy_end", md_busy_m0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
